// File: rtl/core_dmem_responder.sv
// Data-memory responder for the core d_req/d_ack interface: one request in flight,
// programmable acceptance-to-ack latency, sticky protocol-violation flag.

module core_dmem_responder_chk #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 2
) (
   input logic        clk,
   input logic        rst,
   input logic        ack,
   input logic [31:0] rdata,
   input logic        err
);

   if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
      $error("core_dmem_responder: LATENCY must be in 1..15");
   end

   if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
      $error("core_dmem_responder: MEM_WORDS must be a power of two >= 2");
   end

   a_ack_pulse: assert property (@(posedge clk) disable iff (rst) ack |=> !ack)
      else $error("d_req_ack held longer than one cycle");

   a_idle_quiet: assert property (@(posedge clk) disable iff (rst) !ack |-> (rdata == 32'd0 && !err))
      else $error("ack data/error driven outside the ack cycle");

endmodule

module core_dmem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        core_sys_clk,
   input  logic        core_sys_rst,
   input  logic        d_req_val,
   input  logic [31:0] d_req_addr,
   input  logic [2:0]  d_req_cop,
   input  logic [31:0] d_req_wdata,
   input  logic [2:0]  d_req_size,
   output logic        d_req_ack,
   output logic [31:0] d_ack_rdata,
   output logic        d_ack_err,
   output logic        prot_err
);

   localparam int unsigned IDX_W       = $clog2(MEM_WORDS);
   localparam logic [29:0] MEM_WORDS_L = 30'(MEM_WORDS);
   localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);
   localparam logic        LAT_ONE     = (LATENCY == 1);

   localparam logic [2:0] COP_READ  = 3'd0;
   localparam logic [2:0] COP_WRITE = 3'd1;
   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   function automatic logic [3:0] byte_en_f(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << lane;
         SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] read_lane_f(input logic [31:0] word, input logic [2:0] size,
                                               input logic [1:0] lane);
      logic [31:0] res;
      case (size)
         SIZE_BYTE: res = {24'd0, word[{lane, 3'b000} +: 8]};
         SIZE_HALF: res = {16'd0, word[{lane[1], 4'b0000} +: 16]};
         SIZE_WORD: res = word;
         default:   res = 32'd0;
      endcase
      return res;
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  cnt_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [2:0]  cop_r;
   logic [2:0]  size_r;
   logic        ack_r;
   logic [31:0] rdata_r;
   logic        err_r;
   logic        prot_err_r;

   logic [31:0] mem_r [MEM_WORDS];

   logic             accept_s;
   logic             enter_ack_s;
   logic [31:0]      sel_addr_s;
   logic [2:0]       sel_cop_s;
   logic [2:0]       sel_size_s;
   logic [31:0]      off_s;
   logic [IDX_W-1:0] idx_s;
   logic [1:0]       lane_s;
   logic             oor_s;
   logic             misalign_s;
   logic             err_s;
   logic [31:0]      rd_word_s;
   logic             wr_en_s;
   logic [3:0]       be_s;
   logic [31:0]      wr_data_s;
   logic             field_diff_s;

   assign accept_s    = (state_r == ST_IDLE) && d_req_val;
   assign enter_ack_s = (state_nxt_s == ST_ACK);

   // Decode source: live request when accepting with LATENCY=1, latched copy otherwise
   always_comb begin
      sel_addr_s = addr_r;
      sel_cop_s  = cop_r;
      sel_size_s = size_r;
      if (state_r == ST_IDLE) begin
         sel_addr_s = d_req_addr;
         sel_cop_s  = d_req_cop;
         sel_size_s = d_req_size;
      end else begin
         sel_addr_s = addr_r;
         sel_cop_s  = cop_r;
         sel_size_s = size_r;
      end
   end

   // Address decode and error classification
   always_comb begin
      off_s      = sel_addr_s - BASE_ADDR;
      idx_s      = off_s[IDX_W+1:2];
      lane_s     = off_s[1:0];
      oor_s      = (off_s[31:2] >= MEM_WORDS_L);
      misalign_s = 1'b0;
      case (sel_size_s)
         SIZE_HALF: misalign_s = lane_s[0];
         SIZE_WORD: misalign_s = (lane_s != 2'd0);
         default:   misalign_s = 1'b0;
      endcase
      err_s     = oor_s | misalign_s | (sel_cop_s > COP_WRITE) | (sel_size_s > SIZE_WORD);
      rd_word_s = mem_r[idx_s];
   end

   // Write path: commits only at the edge that closes the ACK cycle
   always_comb begin
      wr_en_s = (state_r == ST_ACK) && (cop_r == COP_WRITE) && !err_s;
      be_s    = byte_en_f(size_r, lane_s);
      case (size_r)
         SIZE_BYTE: wr_data_s = {4{wdata_r[7:0]}};
         SIZE_HALF: wr_data_s = {2{wdata_r[15:0]}};
         default:   wr_data_s = wdata_r;
      endcase
   end

   // Any drift of the held request versus the latched copy
   always_comb begin
      field_diff_s = (d_req_addr != addr_r) || (d_req_cop != cop_r) ||
                     (d_req_wdata != wdata_r) || (d_req_size != size_r);
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (d_req_val) begin
               state_nxt_s = LAT_ONE ? ST_ACK : ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r <= 4'd1) begin
               state_nxt_s = ST_ACK;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_ACK:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and latency counter
   always_ff @(posedge core_sys_clk or posedge core_sys_rst) begin
      if (core_sys_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  cnt_r <= CNT_LOAD;
               end else begin
                  cnt_r <= 4'd0;
               end
            end
            ST_WAIT: cnt_r <= cnt_r - 4'd1;
            default: cnt_r <= 4'd0;
         endcase
      end
   end

   // Request capture at acceptance
   always_ff @(posedge core_sys_clk or posedge core_sys_rst) begin
      if (core_sys_rst) begin
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         cop_r   <= 3'd0;
         size_r  <= 3'd0;
      end else if (accept_s) begin
         addr_r  <= d_req_addr;
         wdata_r <= d_req_wdata;
         cop_r   <= d_req_cop;
         size_r  <= d_req_size;
      end else begin
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
         cop_r   <= cop_r;
         size_r  <= size_r;
      end
   end

   // Registered ack outputs; data and error are forced to zero outside the ack cycle
   always_ff @(posedge core_sys_clk or posedge core_sys_rst) begin
      if (core_sys_rst) begin
         ack_r   <= 1'b0;
         rdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         ack_r   <= enter_ack_s;
         err_r   <= enter_ack_s && err_s;
         rdata_r <= (enter_ack_s && !err_s && sel_cop_s == COP_READ) ?
                    read_lane_f(rd_word_s, sel_size_s, lane_s) : 32'd0;
      end
   end

   // Sticky protocol-violation flag
   always_ff @(posedge core_sys_clk or posedge core_sys_rst) begin
      if (core_sys_rst) begin
         prot_err_r <= 1'b0;
      end else if ((state_r == ST_WAIT || state_r == ST_ACK) && (!d_req_val || field_diff_s)) begin
         prot_err_r <= 1'b1;
      end else begin
         prot_err_r <= prot_err_r;
      end
   end

   // Word array, byte-lane writes; contents deliberately not reset
   always_ff @(posedge core_sys_clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_r[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
         end
      end
   end

   assign d_req_ack   = ack_r;
   assign d_ack_rdata = rdata_r;
   assign d_ack_err   = err_r;
   assign prot_err    = prot_err_r;

   core_dmem_responder_chk #(
      .MEM_WORDS (MEM_WORDS),
      .LATENCY   (LATENCY)
   ) u_chk (
      .clk   (core_sys_clk),
      .rst   (core_sys_rst),
      .ack   (ack_r),
      .rdata (rdata_r),
      .err   (err_r)
   );

endmodule
